// File: rtl/lsu_mem_master.sv
// Load/store unit that turns byte, half and word accesses at any alignment into
// 32-bit word-bus transfers, splitting accesses that cross a word boundary.
module lsu_mem_master (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_e;

    state_e      state_q, state_d;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word0_q, word0_d;
    logic [31:0] word1_q, word1_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q;

    logic        accept;
    logic        legal;
    logic        split;
    logic [1:0]  off;
    logic [2:0]  sizeBytes;
    logic [3:0]  mask;
    logic [7:0]  beWide;
    logic [63:0] wdataWide;
    logic [31:0] wordAddr;
    logic [31:0] loadWord;
    logic [31:0] loadExt;

    assign accept = i_req && (state_q == IDLE);

    always_comb begin
        legal = 1'b0;
        if (i_we) begin
            legal = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010);
        end else begin
            legal = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                    (i_funct3 == 3'b100) || (i_funct3 == 3'b101);
        end
    end

    always_comb begin
        mask      = 4'b1111;
        sizeBytes = 3'd4;
        case (funct3_q[1:0])
            2'b00:   begin mask = 4'b0001; sizeBytes = 3'd1; end
            2'b01:   begin mask = 4'b0011; sizeBytes = 3'd2; end
            default: begin mask = 4'b1111; sizeBytes = 3'd4; end
        endcase
    end

    // The 8-lane / 64-bit views hold the first word in the low half and the
    // spill-over into the following word in the high half.
    assign off       = addr_q[1:0];
    assign split     = ({1'b0, off} + sizeBytes) > 3'd4;
    assign beWide    = {4'b0000, mask} << off;
    assign wdataWide = {32'h0000_0000, wdata_q} << {off, 3'b000};
    assign wordAddr  = {addr_q[31:2], 2'b00};

    always_comb begin
        state_d = state_q;
        word0_d = word0_q;
        word1_d = word1_q;
        unique case (state_q)
            IDLE: begin
                if (accept && legal) begin
                    state_d = REQ0;
                end
            end
            REQ0: begin
                if (i_mem_ready) begin
                    if (!we_q) begin
                        state_d = WAIT0;
                    end else if (split) begin
                        state_d = REQ1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WAIT0: begin
                word0_d = i_mem_rdata;
                if (split) begin
                    state_d = REQ1;
                end else begin
                    state_d = DONE;
                end
            end
            REQ1: begin
                if (i_mem_ready) begin
                    if (we_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT1;
                    end
                end
            end
            WAIT1: begin
                word1_d = i_mem_rdata;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        loadWord = 32'({word1_d, word0_d} >> {off, 3'b000});
        case (funct3_q)
            3'b000:  loadExt = {{24{loadWord[7]}}, loadWord[7:0]};
            3'b001:  loadExt = {{16{loadWord[15]}}, loadWord[15:0]};
            3'b100:  loadExt = {24'h000000, loadWord[7:0]};
            3'b101:  loadExt = {16'h0000, loadWord[15:0]};
            default: loadExt = loadWord;
        endcase
        rdata_d = rdata_q;
        if (!we_q && (state_d == DONE) && (state_q != DONE)) begin
            rdata_d = loadExt;
        end
    end

    always_comb begin
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = 32'h0000_0000;
        o_mem_be    = 4'b0000;
        o_mem_wdata = 32'h0000_0000;
        case (state_q)
            REQ0: begin
                o_mem_req   = 1'b1;
                o_mem_we    = we_q;
                o_mem_addr  = wordAddr;
                o_mem_be    = beWide[3:0];
                o_mem_wdata = wdataWide[31:0];
            end
            REQ1: begin
                o_mem_req   = 1'b1;
                o_mem_we    = we_q;
                o_mem_addr  = wordAddr + 32'd4;
                o_mem_be    = beWide[7:4];
                o_mem_wdata = wdataWide[63:32];
            end
            default: begin
            end
        endcase
    end

    assign o_ready = (state_q == IDLE);
    assign o_done  = (state_q == DONE);
    assign o_err   = err_q;
    assign o_rdata = rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0000_0000;
            wdata_q  <= 32'h0000_0000;
            word0_q  <= 32'h0000_0000;
            word1_q  <= 32'h0000_0000;
            rdata_q  <= 32'h0000_0000;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            word0_q <= word0_d;
            word1_q <= word1_d;
            rdata_q <= rdata_d;
            err_q   <= accept && !legal;
            if (accept) begin
                we_q     <= i_we;
                funct3_q <= i_funct3;
                addr_q   <= i_addr;
                wdata_q  <= i_wdata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: a byte-level memory model predicts every
// bus transfer and load result, which a negedge monitor pops and compares.
module tb_lsu_mem_master;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req;
    logic        i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_ready;
    logic        o_done;
    logic        o_err;
    logic [31:0] o_rdata;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ready;
    logic [31:0] i_mem_rdata;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } busTx_t;

    int          errors = 0;
    int          checks = 0;
    int          doneCount = 0;
    busTx_t      txQ[$];
    logic [31:0] rdQ[$];
    logic [31:0] mem[logic [31:0]];
    logic        readPending = 1'b0;
    logic [31:0] pendingData = 32'h0;
    logic [31:0] heldRdata = 32'h0;

    always #5 i_clk = ~i_clk;

    lsu_mem_master dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_we        (i_we),
        .i_funct3    (i_funct3),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_ready     (o_ready),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_rdata     (o_rdata),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_be    (o_mem_be),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ready (i_mem_ready),
        .i_mem_rdata (i_mem_rdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (mem.exists(w)) return mem[w];
        return 32'h0;
    endfunction

    function automatic logic [7:0] memByte(input logic [31:0] a);
        logic [31:0] w;
        w = memWord(a);
        return w[8*int'(a[1:0]) +: 8];
    endfunction

    function automatic int sizeOf(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Builds the expected transfers byte by byte from the access's byte addresses.
    task automatic expectAccess(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input bit expectDone);
        busTx_t      t[2];
        logic [31:0] base;
        logic [31:0] a;
        logic [31:0] val;
        int          j;
        int          lane;
        base = {addr[31:2], 2'b00};
        for (int k = 0; k < 2; k++) begin
            t[k].we    = we;
            t[k].addr  = base + 32'(4 * k);
            t[k].be    = 4'b0000;
            t[k].wdata = 32'h0;
        end
        val = 32'h0;
        for (int i = 0; i < sizeOf(f3); i++) begin
            a    = addr + 32'(i);
            j    = ({a[31:2], 2'b00} == base) ? 0 : 1;
            lane = int'(a[1:0]);
            t[j].be[lane] = 1'b1;
            t[j].wdata[8*lane +: 8] = wdata[8*i +: 8];
            val[8*i +: 8] = memByte(a);
        end
        if (f3 == 3'b000) val = {{24{val[7]}}, val[7:0]};
        if (f3 == 3'b001) val = {{16{val[15]}}, val[15:0]};
        txQ.push_back(t[0]);
        if (t[1].be != 4'b0000) txQ.push_back(t[1]);
        if (expectDone) begin
            if (!we) heldRdata = val;
            rdQ.push_back(heldRdata);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int stall, input int latency,
                                 input bit busyReq);
        int edges;
        expectAccess(we, f3, addr, wdata, 1'b1);
        i_mem_ready = (stall == 0);
        i_req    = 1'b1;
        i_we     = we;
        i_funct3 = f3;
        i_addr   = addr;
        i_wdata  = wdata;
        checkOutput("readyBeforeReq", 32'(o_ready), 32'd1);
        @(posedge i_clk);
        #1;
        if (busyReq) begin
            i_we     = 1'b1;
            i_funct3 = 3'b010;
            i_addr   = 32'h0000_0100;
            i_wdata  = 32'hFFFF_FFFF;
        end else begin
            i_req = 1'b0;
        end
        edges = 0;
        for (int s = 0; s < stall; s++) begin
            @(posedge i_clk);
            edges++;
        end
        if (stall > 0) #1;
        i_mem_ready = 1'b1;
        while (!o_done && edges < 40) begin
            @(posedge i_clk);
            #1;
            edges++;
        end
        i_req = 1'b0;
        // Latency counts through the edge that closes the o_done cycle.
        checkOutput("latency", 32'(edges + 1), 32'(latency));
        @(posedge i_clk);
        #1;
        checkOutput("donePulseEnds", 32'(o_done), 32'd0);
        checkOutput("readyAfterDone", 32'(o_ready), 32'd1);
    endtask

    always @(posedge i_clk) begin
        #1;
        if (readPending) begin
            i_mem_rdata = pendingData;
            readPending = 1'b0;
        end else begin
            i_mem_rdata = 32'hDEAD_BEEF;
        end
    end

    always @(negedge i_clk) begin
        busTx_t      e;
        logic [31:0] w;
        if (!i_rst && o_mem_req) begin
            checkOutput("busReqExpected", 32'(txQ.size() != 0), 32'd1);
            if (txQ.size() != 0) begin
                e = txQ[0];
                checkOutput("busWe", 32'(o_mem_we), 32'(e.we));
                checkOutput("busAddr", o_mem_addr, e.addr);
                checkOutput("busBe", 32'(o_mem_be), 32'(e.be));
                if (e.we) checkOutput("busWdata", o_mem_wdata, e.wdata);
                if (i_mem_ready) begin
                    void'(txQ.pop_front());
                    if (e.we) begin
                        w = memWord(e.addr);
                        for (int k = 0; k < 4; k++) begin
                            if (e.be[k]) w[8*k +: 8] = e.wdata[8*k +: 8];
                        end
                        mem[e.addr] = w;
                    end else begin
                        pendingData = memWord(e.addr);
                        readPending = 1'b1;
                    end
                end
            end
        end
        if (!i_rst && o_done) begin
            doneCount++;
            checkOutput("doneExpected", 32'(rdQ.size() != 0), 32'd1);
            if (rdQ.size() != 0) checkOutput("rdata", o_rdata, rdQ.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int savedDone;
        i_rst       = 1'b1;
        i_req       = 1'b0;
        i_we        = 1'b0;
        i_funct3    = 3'b000;
        i_addr      = 32'h0;
        i_wdata     = 32'h0;
        i_mem_ready = 1'b1;
        i_mem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(posedge i_clk);
        #1;
        checkOutput("rstReady", 32'(o_ready), 32'd1);
        checkOutput("rstDone", 32'(o_done), 32'd0);
        checkOutput("rstErr", 32'(o_err), 32'd0);
        checkOutput("rstMemReq", 32'(o_mem_req), 32'd0);
        checkOutput("rstMemWe", 32'(o_mem_we), 32'd0);
        checkOutput("rstMemBe", 32'(o_mem_be), 32'd0);
        checkOutput("rstMemAddr", o_mem_addr, 32'd0);
        checkOutput("rstMemWdata", o_mem_wdata, 32'd0);
        checkOutput("rstRdata", o_rdata, 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        applyStimulus(1'b1, 3'b010, 32'h0000_0005, 32'hAABB_CCDD, 0, 3, 1'b0);
        checkOutput("swSplitWord0", memWord(32'h4), 32'hBBCC_DD00);
        checkOutput("swSplitWord1", memWord(32'h8), 32'h0000_00AA);

        mem[32'h4] = 32'h8011_2233;
        mem[32'h8] = 32'h4455_66F7;
        applyStimulus(1'b0, 3'b001, 32'h0000_0007, 32'h0, 0, 5, 1'b0);
        checkOutput("lhSplit", o_rdata, 32'hFFFF_F780);
        applyStimulus(1'b0, 3'b101, 32'h0000_0007, 32'h0, 0, 5, 1'b0);
        checkOutput("lhuSplit", o_rdata, 32'h0000_F780);

        mem[32'h0] = 32'h8000_0000;
        applyStimulus(1'b0, 3'b000, 32'h0000_0003, 32'h0, 0, 3, 1'b0);
        checkOutput("lbHighLane", o_rdata, 32'hFFFF_FF80);

        mem[32'h10] = 32'h1234_5678;
        applyStimulus(1'b0, 3'b010, 32'h0000_0010, 32'h0, 2, 5, 1'b1);
        checkOutput("lwStalled", o_rdata, 32'h1234_5678);

        applyStimulus(1'b1, 3'b010, 32'hFFFF_FFFE, 32'h1122_3344, 0, 3, 1'b0);
        checkOutput("swWrapTop", memWord(32'hFFFF_FFFC), 32'h3344_0000);
        checkOutput("swWrapZero", memWord(32'h0), 32'h8000_1122);

        applyStimulus(1'b1, 3'b001, 32'h0000_0040, 32'h0000_BEEF, 0, 2, 1'b0);
        applyStimulus(1'b1, 3'b000, 32'h0000_0043, 32'h0000_005A, 0, 2, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h0000_0040, 32'h0, 0, 3, 1'b0);
        checkOutput("lwReadBack", o_rdata, 32'h5A00_BEEF);
        applyStimulus(1'b0, 3'b100, 32'h0000_0043, 32'h0, 0, 3, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h0000_0041, 32'h0, 0, 5, 1'b0);
        checkOutput("lwSplitReadBack", o_rdata, 32'h005A_00BE);
        applyStimulus(1'b1, 3'b001, 32'h0000_0042, 32'h0000_7766, 0, 2, 1'b0);
        applyStimulus(1'b0, 3'b001, 32'h0000_0042, 32'h0, 0, 3, 1'b0);

        i_req    = 1'b1;
        i_we     = 1'b0;
        i_funct3 = 3'b011;
        i_addr   = 32'h0000_0200;
        @(posedge i_clk);
        #1;
        i_req = 1'b0;
        checkOutput("loadErrPulse", 32'(o_err), 32'd1);
        checkOutput("loadErrReady", 32'(o_ready), 32'd1);
        @(posedge i_clk);
        #1;
        checkOutput("loadErrClears", 32'(o_err), 32'd0);
        i_req    = 1'b1;
        i_we     = 1'b1;
        i_funct3 = 3'b100;
        @(posedge i_clk);
        #1;
        i_req = 1'b0;
        checkOutput("storeErrPulse", 32'(o_err), 32'd1);
        repeat (2) @(posedge i_clk);
        #1;

        mem[32'h20] = 32'hCAFE_F00D;
        mem[32'h24] = 32'h0BAD_F00D;
        savedDone = doneCount;
        expectAccess(1'b0, 3'b010, 32'h0000_0022, 32'h0, 1'b0);
        i_mem_ready = 1'b1;
        i_req    = 1'b1;
        i_we     = 1'b0;
        i_funct3 = 3'b010;
        i_addr   = 32'h0000_0022;
        @(posedge i_clk);
        #1;
        i_req = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        heldRdata = 32'h0;
        checkOutput("abortReady", 32'(o_ready), 32'd1);
        checkOutput("abortDone", 32'(o_done), 32'd0);
        checkOutput("abortRdata", o_rdata, 32'h0);
        checkOutput("abortMemReq", 32'(o_mem_req), 32'd0);
        repeat (4) @(posedge i_clk);
        #1;
        checkOutput("abortNoDone", 32'(doneCount), 32'(savedDone));
        checkOutput("busQueueDrained", 32'(txQ.size()), 32'd0);
        checkOutput("rdataQueueDrained", 32'(rdQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
